// File: rtl/branch_predictor_table_pkg.sv
// Shared constants and helpers for the branch direction predictor.
// Holds the counter reset value and the parameter legality check.
package bp_pkg;

    localparam int unsigned STAT_W    = 32;
    localparam int unsigned CNT_W_MAX = 4;

    // Weakly not-taken value for a counter of the given width.
    function automatic logic [CNT_W_MAX-1:0] cnt_reset(input int unsigned cnt_w);
        return CNT_W_MAX'((32'd1 << (cnt_w - 32'd1)) - 32'd1);
    endfunction

    function automatic bit params_legal(input int unsigned idx_w,
                                        input int unsigned cnt_w,
                                        input int unsigned ghr_w);
        return (idx_w >= 1) && (idx_w <= 12) &&
               (cnt_w >= 1) && (cnt_w <= CNT_W_MAX) &&
               (ghr_w >= 1) && (ghr_w <= idx_w);
    endfunction

endpackage

// File: rtl/branch_predictor_table_if.sv
// Lookup/update/status bundle between the pipeline and the predictor.
// The core (master) drives the fetch PC and the resolved outcome.
interface branch_predictor_table_if
    import bp_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned GHR_W = 6
);

    logic [PC_W-1:0]   pred_pc;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_idx;
    logic              upd_valid;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              upd_mispred;
    logic [GHR_W-1:0]  ghr;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output pred_pc, upd_valid, upd_idx, upd_taken, upd_mispred,
        input  pred_taken, pred_idx, ghr, stat_branches, stat_mispred
    );

    modport slave (
        input  pred_pc, upd_valid, upd_idx, upd_taken, upd_mispred,
        output pred_taken, pred_idx, ghr, stat_branches, stat_mispred
    );

endinterface

// File: rtl/branch_predictor_table_sat_counter.sv
// Saturating up/down counter with enable and an asynchronous reset value.
// Used for every table entry and for both statistics counters.
module bp_sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         up_i,
    input  logic [W-1:0] rst_val_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= rst_val_i;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (up_i) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + W'(1);
            end else begin
                if (cnt_q != '0) cnt_d = cnt_q - W'(1);
            end
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_table.sv
// Direct-mapped bimodal/gshare direction predictor with resolved-outcome
// global history and saturating branch/mispredict statistics.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned GHR_W  = 6,
    parameter bit          GSHARE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_predictor_table_if.slave  bp
);

    localparam int unsigned       ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CNT_RST = CNT_W'(cnt_reset(CNT_W));

    if (!params_legal(IDX_W, CNT_W, GHR_W)) begin : g_illegal_params
        $error("branch_predictor_table: illegal IDX_W/CNT_W/GHR_W combination");
    end

    logic [CNT_W-1:0] tbl_cnt [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [IDX_W-1:0] base_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic             unused_pc;

    // Flop-based table so every entry resets asynchronously.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_tbl
        bp_sat_counter #(.W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .en_i      (bp.upd_valid && (bp.upd_idx == IDX_W'(i))),
            .up_i      (bp.upd_taken),
            .rst_val_i (CNT_RST),
            .cnt_o     (tbl_cnt[i])
        );
    end

    assign base_idx   = bp.pred_pc[IDX_W+1:2];
    assign lookup_idx = GSHARE ? (base_idx ^ IDX_W'(ghr_q)) : base_idx;

    assign bp.pred_idx   = lookup_idx;
    assign bp.pred_taken = tbl_cnt[lookup_idx][CNT_W-1];
    assign bp.ghr        = ghr_q;

    // Non-speculative history: shift in the resolved direction, newest at bit 0.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid) ghr_d = GHR_W'({ghr_q, bp.upd_taken});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    bp_sat_counter #(.W(STAT_W)) u_stat_br (
        .clk       (clk),
        .rst       (rst),
        .en_i      (bp.upd_valid),
        .up_i      (1'b1),
        .rst_val_i ('0),
        .cnt_o     (bp.stat_branches)
    );

    bp_sat_counter #(.W(STAT_W)) u_stat_mp (
        .clk       (clk),
        .rst       (rst),
        .en_i      (bp.upd_valid && bp.upd_mispred),
        .up_i      (1'b1),
        .rst_val_i ('0),
        .cnt_o     (bp.stat_mispred)
    );

    assign unused_pc = ^{bp.pred_pc[PC_W-1:IDX_W+2], bp.pred_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a bimodal and a gshare instance share
// one stimulus stream and are compared every cycle against a table model.
module tb_branch_predictor_table;

    logic        clk;
    logic        rst;
    logic [31:0] pc_r;
    logic        v_r;
    logic [5:0]  idx_r;
    logic        t_r;
    logic        mp_r;
    bit          chk_en;

    int checks = 0;
    int errors = 0;

    branch_predictor_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) bim_if ();
    branch_predictor_table_if #(.PC_W(32), .IDX_W(6), .GHR_W(4)) gs_if ();

    assign bim_if.pred_pc     = pc_r;
    assign bim_if.upd_valid   = v_r;
    assign bim_if.upd_idx     = idx_r;
    assign bim_if.upd_taken   = t_r;
    assign bim_if.upd_mispred = mp_r;
    assign gs_if.pred_pc      = pc_r;
    assign gs_if.upd_valid    = v_r;
    assign gs_if.upd_idx      = idx_r;
    assign gs_if.upd_taken    = t_r;
    assign gs_if.upd_mispred  = mp_r;

    branch_predictor_table #(.PC_W(32), .IDX_W(6), .CNT_W(2), .GHR_W(6), .GSHARE(1'b0)) u_bim (
        .clk (clk), .rst (rst), .bp (bim_if)
    );

    branch_predictor_table #(.PC_W(32), .IDX_W(6), .CNT_W(2), .GHR_W(4), .GSHARE(1'b1)) u_gs (
        .clk (clk), .rst (rst), .bp (gs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: index 0 = bimodal instance, index 1 = gshare instance.
    int     m_tb [2][64];
    int     m_gh [2];
    longint m_br [2];
    longint m_mp [2];
    int     gh_mod [2] = '{64, 16};

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 64; e++) m_tb[d][e] = 1;
            m_gh[d] = 0;
            m_br[d] = 0;
            m_mp[d] = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else if (v_r) begin
            for (int d = 0; d < 2; d++) begin
                if (t_r) m_tb[d][idx_r] = (m_tb[d][idx_r] < 3) ? m_tb[d][idx_r] + 1 : 3;
                else     m_tb[d][idx_r] = (m_tb[d][idx_r] > 0) ? m_tb[d][idx_r] - 1 : 0;
                m_gh[d] = (m_gh[d] * 2 + (t_r ? 1 : 0)) % gh_mod[d];
                if (m_br[d] < 64'hFFFF_FFFF) m_br[d] = m_br[d] + 1;
                if (mp_r && m_mp[d] < 64'hFFFF_FFFF) m_mp[d] = m_mp[d] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int bi;
        int gi;
        if (chk_en) begin
            bi = int'(pc_r / 4) % 64;
            gi = bi ^ m_gh[1];
            chk("bim_pred_idx",   32'(bim_if.pred_idx),   32'(bi));
            chk("bim_pred_taken", 32'(bim_if.pred_taken), (m_tb[0][bi] >= 2) ? 32'd1 : 32'd0);
            chk("bim_ghr",        32'(bim_if.ghr),        32'(m_gh[0]));
            chk("bim_stat_br",    bim_if.stat_branches,   32'(m_br[0]));
            chk("bim_stat_mp",    bim_if.stat_mispred,    32'(m_mp[0]));
            chk("gs_pred_idx",    32'(gs_if.pred_idx),    32'(gi));
            chk("gs_pred_taken",  32'(gs_if.pred_taken),  (m_tb[1][gi] >= 2) ? 32'd1 : 32'd0);
            chk("gs_ghr",         32'(gs_if.ghr),         32'(m_gh[1]));
            chk("gs_stat_br",     gs_if.stat_branches,    32'(m_br[1]));
            chk("gs_stat_mp",     gs_if.stat_mispred,     32'(m_mp[1]));
        end
    end

    task automatic upd(input int idx, input bit t, input bit mp);
        @(posedge clk);
        #1;
        v_r   = 1'b1;
        idx_r = 6'(idx);
        t_r   = t;
        mp_r  = mp;
        @(posedge clk);
        #1;
        v_r  = 1'b0;
        t_r  = 1'b0;
        mp_r = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        pc_r   = 32'h40;
        v_r    = 1'b0;
        idx_r  = '0;
        t_r    = 1'b0;
        mp_r   = 1'b0;
        chk_en = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, bimodal index of 0x40.
        chk("lit_rst_idx",   32'(bim_if.pred_idx),   32'h10);
        chk("lit_rst_taken", 32'(bim_if.pred_taken), 32'h0);
        chk("lit_rst_br",    bim_if.stat_branches,   32'h0);

        // Counter training and saturation at idx 0x10.
        upd(16, 1'b1, 1'b0);
        chk("lit_cnt_one_taken", 32'(bim_if.pred_taken), 32'h1);
        upd(16, 1'b1, 1'b0);
        chk("lit_cnt_sat_pre", 32'(u_bim.tbl_cnt[16]), 32'h3);
        upd(16, 1'b1, 1'b0);
        chk("lit_cnt_sat", 32'(u_bim.tbl_cnt[16]), 32'h3);
        upd(16, 1'b0, 1'b0);
        upd(16, 1'b0, 1'b0);
        chk("lit_cnt_down",   32'(u_bim.tbl_cnt[16]), 32'h1);
        chk("lit_taken_down", 32'(bim_if.pred_taken), 32'h0);

        // History 1,0,1,1 and gshare index.
        do_reset();
        upd(5, 1'b1, 1'b0);
        upd(5, 1'b0, 1'b0);
        upd(5, 1'b1, 1'b1);
        upd(5, 1'b1, 1'b0);
        chk("lit_gs_ghr",  32'(gs_if.ghr),      32'hB);
        chk("lit_gs_idx",  32'(gs_if.pred_idx), 32'h1B);
        chk("lit_bim_ghr", 32'(bim_if.ghr),     32'h0B);
        chk("lit_br4",     bim_if.stat_branches, 32'd4);
        chk("lit_mp1",     bim_if.stat_mispred,  32'd1);

        // Same-cycle update and lookup: no bypass.
        do_reset();
        @(posedge clk);
        #1;
        v_r   = 1'b1;
        idx_r = 6'h10;
        t_r   = 1'b1;
        #3;
        chk("lit_nobypass_same", 32'(bim_if.pred_taken), 32'h0);
        @(posedge clk);
        #1;
        v_r = 1'b0;
        t_r = 1'b0;
        chk("lit_nobypass_next", 32'(bim_if.pred_taken), 32'h1);

        // Mispredict statistic saturation.
        @(posedge clk);
        #2;
        force u_bim.u_stat_mp.cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_bim.u_stat_mp.cnt_q;
        m_mp[0] = 64'hFFFF_FFFE;
        upd(3, 1'b0, 1'b1);
        upd(3, 1'b0, 1'b1);
        upd(3, 1'b0, 1'b1);
        chk("lit_mp_sat",    bim_if.stat_mispred, 32'hFFFF_FFFF);
        chk("lit_gs_mp3",    gs_if.stat_mispred,  32'd3);
        @(posedge clk);
        #1;
        mp_r = 1'b1;
        @(posedge clk);
        #1;
        mp_r = 1'b0;
        chk("lit_mp_novalid", bim_if.stat_mispred,  32'hFFFF_FFFF);
        chk("lit_br_novalid", bim_if.stat_branches, 32'd4);

        // Asynchronous reset mid-stream, with an update lost under reset.
        upd(16, 1'b1, 1'b1);
        upd(9, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        v_r   = 1'b1;
        idx_r = 6'h10;
        t_r   = 1'b1;
        mp_r  = 1'b1;
        #1;
        chk("lit_arst_ghr",   32'(bim_if.ghr),        32'h0);
        chk("lit_arst_br",    bim_if.stat_branches,   32'h0);
        chk("lit_arst_mp",    bim_if.stat_mispred,    32'h0);
        chk("lit_arst_gs_br", gs_if.stat_branches,    32'h0);
        chk("lit_arst_taken", 32'(bim_if.pred_taken), 32'h0);
        chk("lit_arst_gsidx", 32'(gs_if.pred_idx),    32'h10);
        for (int e = 0; e < 64; e++) begin
            chk("arst_tbl_bim", 32'(u_bim.tbl_cnt[e]), 32'(m_tb[0][e]));
            chk("arst_tbl_gs",  32'(u_gs.tbl_cnt[e]),  32'h1);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        v_r  = 1'b0;
        t_r  = 1'b0;
        mp_r = 1'b0;
        chk("lit_lost_upd", 32'(u_bim.tbl_cnt[16]), 32'h1);
        chk("lit_lost_br",  bim_if.stat_branches,   32'h0);

        // A few more mixed updates for the per-cycle compare.
        pc_r = 32'h1234_5678;
        upd(30, 1'b1, 1'b0);
        upd(30, 1'b1, 1'b1);
        pc_r = 32'h0000_0078;
        upd(7, 1'b0, 1'b1);
        upd(30, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
# branch_predictor_table

Parametrised direct-mapped branch direction predictor for the pipelined core: a table of 2^IDX_W saturating counters indexed by PC, either directly (bimodal) or PC XOR global history (gshare). IF looks up a prediction combinationally, and EX writes the resolved outcome back through a separate update port. The block also keeps a resolved-outcome global history register and saturating branch and mispredict statistics counters. It is the successor to the single-state one-bit predictor and generalises it in table depth, counter width and indexing mode.

## Interface
Parameters:
- PC_W, 32, PC width.
- IDX_W, 6, index bits; table has 2^IDX_W entries; legal 1..12.
- CNT_W, 2, counter width; legal 1..4 (1 = one-bit predictor per entry).
- GHR_W, 6, global history length; legal 1..IDX_W.
- GSHARE, 0, 0 = bimodal index, 1 = gshare index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pred_pc  in  PC_W  fetch PC to predict.
- pred_taken  out  1  predicted direction for pred_pc.
- pred_idx  out  IDX_W  table index used; carried down the pipe and returned as upd_idx.
- upd_valid  in  1  a branch resolved this cycle.
- upd_idx  in  IDX_W  index that was used when this branch was predicted.
- upd_taken  in  1  resolved direction.
- upd_mispred  in  1  resolved direction differed from prediction.
- ghr  out  GHR_W  current global history, bit 0 = newest.
- stat_branches  out  32  count of resolved branches.
- stat_mispred  out  32  count of mispredicts.

## Operation
- Index: base = pred_pc[IDX_W+1:2]. With GSHARE=1: pred_idx = base XOR zero-extended ghr. With GSHARE=0: pred_idx = base.
- Prediction: pred_taken = MSB of counter[pred_idx]. Purely combinational; no valid qualifier.
- Counter reset value is weakly not-taken: 2^(CNT_W-1)-1 (2'b01 for CNT_W=2; 0 for CNT_W=1).
- Update when upd_valid=1:
  - If upd_taken=1: counter[upd_idx] += 1, saturating at 2^CNT_W-1.
  - If upd_taken=0: counter[upd_idx] -= 1, saturating at 0.
  - ghr <= {ghr[GHR_W-2:0], upd_taken}; for GHR_W=1, ghr <= upd_taken.
  - stat_branches += 1, saturating at 32'hFFFF_FFFF.
  - If upd_mispred=1: stat_mispred += 1, also saturating.
- upd_valid=0: no state changes. upd_taken and upd_mispred are ignored.
- upd_mispred=1 with upd_valid=0 is ignored.
- The history register is non-speculative: it reflects resolved branches only. The block does no repair on flush.

## Timing
- Prediction latency is 0 cycles (combinational from pred_pc and registered state). Update latency is 1 cycle: the new counter, ghr and stats are visible after the clock edge.
- Same-cycle lookup and update to the same index: pred_taken shows the pre-update value. There is no bypass.
- With GSHARE=1, an update also changes ghr, so pred_idx for an unchanged pred_pc may change in the next cycle. This is required behaviour.
- rst asserted at any time, including mid-stream: all counters go to the weak not-taken value, ghr=0 and both stats=0 immediately. pred_taken=0 and pred_idx=base while rst is high. An update presented in the same cycle that rst is high is lost.
- Outputs after reset: pred_taken=0, ghr=0, stat_branches=0, stat_mispred=0.

## Structure
- Shared package bp_pkg:
  - function cnt_reset(CNT_W), returning the weak not-taken value.
  - constant STAT_W=32.
  - parameter legality checks (elaboration-time assertions on IDX_W, CNT_W and GHR_W ranges).
- One sub-module, bp_sat_counter, is natural: a width-parameterised saturating up/down counter with enable and a reset value input. Two copies of bp_sat_counter serve as the statistics counters, and the same increment/decrement logic is used for table entries.
- The table is a flop array, not SRAM, because the block needs a per-entry asynchronous reset.

## Test plan
- Reset, then pred_pc=0x40, bimodal, CNT_W=2 -> pred_idx=0x10, pred_taken=0, stat_branches=0.
- Two updates to idx 0x10 with taken=1 -> counter 01->10->11 and pred_taken=1 after the second edge; a third taken update saturates at 11. Two not-taken updates give 11->10->01, so pred_taken=0.
- GSHARE=1, GHR_W=4: updates with taken sequence 1,0,1,1 -> ghr=4'b1011. Then pred_pc=0x40 -> pred_idx=0x10^0x0B=0x1B.
- Same-cycle update (taken, idx 0x10, counter 01) and lookup of 0x10 -> pred_taken=0 that cycle, 1 the next.
- Preload stat_mispred to 0xFFFF_FFFE via force, then 3 updates with mispred=1 -> stat_mispred holds 0xFFFF_FFFF. An update with upd_valid=0 and mispred=1 causes no change.
- rst pulsed high mid-stream, asynchronous to clk -> all counters read back 01, ghr=0 and stats=0 before the next edge.
